// File: rtl/ltssm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ltssm_pkg
// Description : Shared LTSSM definitions. Holds the Receiver Detection
//               sequencer state type and a small constant helper used to
//               size the sequencer's down-counter.
// Revision    : 1.0  initial release
// ============================================================================
package ltssm_pkg;

    // Receiver Detection sequencer states.
    typedef enum logic [2:0] {
        RXDET_IDLE    = 3'd0,
        RXDET_CHARGE  = 3'd1,
        RXDET_SAMPLE  = 3'd2,
        RXDET_REPORT  = 3'd3,
        RXDET_RETRY   = 3'd4,
        RXDET_HOLDOFF = 3'd5
    } rxdet_sm_e;

    // Largest of three integers. Used at elaboration time only.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage : ltssm_pkg
`default_nettype wire

// File: rtl/rxdet_lane_filter.sv
`default_nettype none
// ============================================================================
// Module      : rxdet_lane_filter
// Description : Per-lane AND accumulator for the receiver-detect comparators.
//               A lane survives only if its comparator is high on every
//               enabled cycle since the last clear.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               clr_i   - preset every lane of the accumulator to 1
//               en_i    - fold the current comparator values in (acc &= cmp)
//               cmp_i   - per-lane comparator inputs
//               acc_o   - registered accumulator
// Revision    : 1.0  initial release
// ============================================================================
module rxdet_lane_filter #(
    parameter int NUM_LANES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [NUM_LANES-1:0] cmp_i,
    output logic [NUM_LANES-1:0] acc_o
);

    logic [NUM_LANES-1:0] r_acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
        end else if (clr_i) begin
            r_acc <= '1;
        end else if (en_i) begin
            r_acc <= r_acc & cmp_i;
        end
    end

    assign acc_o = r_acc;

endmodule : rxdet_lane_filter
`default_nettype wire

// File: rtl/rxdet_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rxdet_sequencer
// Description : PCIe Receiver Detection sequencer. While the Detect
//               controller holds detect_active_i, charges the TX common mode
//               on all lanes, filters the per-lane detect comparators, and
//               reports the result with a one-cycle lane_detect_o pulse plus
//               a registered presence mask. Retries after a gap when no
//               receiver is found; holds off after a success until the
//               controller leaves Detect.Active.
// Ports       : clk_i            - clock
//               rst_ni           - asynchronous active-low reset
//               detect_active_i  - high while the controller is in Detect.Active
//               rxdet_cmp_i      - per-lane analog detect comparators
//               rxdet_en_o       - per-lane charge/detect enable
//               tx_elec_idle_o   - TX electrical idle request
//               lane_detect_o    - one-cycle "receiver present" pulse
//               lanes_present_o  - presence mask from the last completed attempt
//               busy_o           - attempt in progress (CHARGE..RETRY)
// Revision    : 1.0  initial release
// ============================================================================
module rxdet_sequencer
    import ltssm_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 4,
    parameter int RETRY_GAP     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 detect_active_i,
    input  logic [NUM_LANES-1:0] rxdet_cmp_i,
    output logic [NUM_LANES-1:0] rxdet_en_o,
    output logic                 tx_elec_idle_o,
    output logic                 lane_detect_o,
    output logic [NUM_LANES-1:0] lanes_present_o,
    output logic                 busy_o
);

    // Counter holds at most max-1, so $clog2(max) bits suffice; keep at
    // least one bit so that all-ones-cycle parameterisations still elaborate.
    localparam int CNT_MAX = max3(SETTLE_CYCLES, SAMPLE_CYCLES, RETRY_GAP);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] c_settle_ld = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_sample_ld = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_retry_ld  = CNT_W'(RETRY_GAP - 1);

    rxdet_sm_e            r_state;
    rxdet_sm_e            w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_cnt_zero;
    logic [NUM_LANES-1:0] r_lanes_present;
    logic [NUM_LANES-1:0] w_acc;
    logic                 w_filt_clr;
    logic                 w_filt_en;
    logic                 w_load_present;

    assign w_cnt_zero = (r_cnt == '0);

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RXDET_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and output decode. Outputs depend on r_state
    // (and the registered mask) only, never on the inputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        // Saturating decrement: the counter never wraps below zero.
        w_cnt_next     = w_cnt_zero ? r_cnt : (r_cnt - CNT_W'(1));
        rxdet_en_o     = '0;
        tx_elec_idle_o = 1'b1;
        lane_detect_o  = 1'b0;
        busy_o         = 1'b0;

        case (r_state)
            RXDET_IDLE: begin
                if (detect_active_i) begin
                    w_state_next = RXDET_CHARGE;
                    w_cnt_next   = c_settle_ld;
                end
            end

            RXDET_CHARGE: begin
                rxdet_en_o     = '1;
                tx_elec_idle_o = 1'b0;
                busy_o         = 1'b1;
                if (!detect_active_i) begin
                    w_state_next = RXDET_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_next = RXDET_SAMPLE;
                    w_cnt_next   = c_sample_ld;
                end
            end

            RXDET_SAMPLE: begin
                rxdet_en_o     = '1;
                tx_elec_idle_o = 1'b0;
                busy_o         = 1'b1;
                // Abort wins over completing the attempt, even on the
                // final sample cycle.
                if (!detect_active_i) begin
                    w_state_next = RXDET_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_next = RXDET_REPORT;
                end
            end

            RXDET_REPORT: begin
                busy_o        = 1'b1;
                lane_detect_o = |r_lanes_present;
                if (|r_lanes_present) begin
                    w_state_next = RXDET_HOLDOFF;
                end else begin
                    w_state_next = RXDET_RETRY;
                    w_cnt_next   = c_retry_ld;
                end
            end

            RXDET_RETRY: begin
                busy_o = 1'b1;
                if (!detect_active_i) begin
                    w_state_next = RXDET_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_next = RXDET_CHARGE;
                    w_cnt_next   = c_settle_ld;
                end
            end

            RXDET_HOLDOFF: begin
                if (!detect_active_i) begin
                    w_state_next = RXDET_IDLE;
                end
            end

            default: begin
                w_state_next = RXDET_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Comparator filter. Presetting throughout CHARGE leaves the
    // accumulator all-ones on the first SAMPLE cycle.
    // ------------------------------------------------------------------
    assign w_filt_clr = (r_state == RXDET_CHARGE);
    assign w_filt_en  = (r_state == RXDET_SAMPLE);

    rxdet_lane_filter #(
        .NUM_LANES (NUM_LANES)
    ) u_lane_filter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_filt_clr),
        .en_i   (w_filt_en),
        .cmp_i  (rxdet_cmp_i),
        .acc_o  (w_acc)
    );

    // The mask is captured on the edge entering REPORT. The final sample
    // cycle's comparator is folded in here, since the filter register
    // would only absorb it on that same edge.
    assign w_load_present = (r_state == RXDET_SAMPLE) &&
                            (w_state_next == RXDET_REPORT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lanes_present <= '0;
        end else if (w_load_present) begin
            r_lanes_present <= w_acc & rxdet_cmp_i;
        end
    end

    assign lanes_present_o = r_lanes_present;

endmodule : rxdet_sequencer
`default_nettype wire

// File: doc/rxdet_sequencer.md
# rxdet_sequencer

Runs the PCIe Receiver Detection sequence for the transmitter side of the physical layer. It sits between the LTSSM Detect controller and the per-lane analog receiver-detect circuitry. While the controller is in Detect.Active, the block charges the TX common mode on every lane, then filters each lane's detect comparator. It returns a single-cycle "receiver present" notification to the controller, plus a registered per-lane presence mask for later lane configuration.

## Interface
Parameters:
- NUM_LANES, 4, number of lanes probed in parallel
- SETTLE_CYCLES, 16, cycles the charge pulse is held before sampling starts (≥1)
- SAMPLE_CYCLES, 4, consecutive comparator-high cycles a lane needs to count as present (≥1)
- RETRY_GAP, 8, idle cycles between attempts when no receiver is found (≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- detect_active_i  in  1  level from the Detect controller; high while in Detect.Active
- rxdet_cmp_i  in  NUM_LANES  per-lane analog comparator; high means a receiver load is sensed
- rxdet_en_o  out  NUM_LANES  per-lane charge/detect enable to the analog front end
- tx_elec_idle_o  out  1  TX electrical idle request; high except while charging or sampling
- lane_detect_o  out  1  one-cycle pulse: at least one lane has a receiver (drives the controller's lane-detect input)
- lanes_present_o  out  NUM_LANES  registered presence mask from the last completed attempt
- busy_o  out  1  high in CHARGE, SAMPLE, REPORT and RETRY

## Operation
- States: IDLE, CHARGE, SAMPLE, REPORT, RETRY, HOLDOFF.
- IDLE: all enables low, tx_elec_idle_o=1. Go to CHARGE when detect_active_i=1.
- CHARGE:
  - rxdet_en_o all ones, tx_elec_idle_o=0.
  - Down-counter loads SETTLE_CYCLES-1 on entry.
  - Go to SAMPLE when the counter reaches 0.
- SAMPLE:
  - rxdet_en_o stays all ones. Counter loads SAMPLE_CYCLES-1.
  - Per-lane accumulator is set to all ones on entry. Each cycle: acc &= rxdet_cmp_i.
  - Go to REPORT when the counter reaches 0; that last cycle's comparator value is included.
- REPORT (one cycle):
  - rxdet_en_o=0, tx_elec_idle_o=1.
  - lanes_present_o is loaded with acc on the clock edge entering REPORT.
  - lane_detect_o = |lanes_present_o during REPORT only.
  - If any lane is present, go to HOLDOFF; otherwise go to RETRY.
- RETRY: counter loads RETRY_GAP-1. At 0, go to CHARGE if detect_active_i=1, else IDLE.
- HOLDOFF: wait for detect_active_i=0, then go to IDLE. No re-probe while the controller stays active.
- Abort:
  - detect_active_i=0 in CHARGE, SAMPLE or RETRY goes to IDLE on the next edge.
  - rxdet_en_o drops that cycle.
  - lanes_present_o is not updated; no pulse.
- Simultaneous events: deassertion in the final SAMPLE cycle still aborts. Abort has priority over the REPORT transition.
- Counter width: $clog2(max(SETTLE_CYCLES,SAMPLE_CYCLES,RETRY_GAP)). It only decrements and never wraps.

## Timing
- Reset values:
  - state=IDLE
  - rxdet_en_o=0
  - tx_elec_idle_o=1
  - lane_detect_o=0
  - lanes_present_o=0
  - busy_o=0
- Cycle numbering: detect_active_i is sampled high at edge 0.
  - CHARGE occupies cycles 1..SETTLE_CYCLES.
  - SAMPLE occupies the next SAMPLE_CYCLES cycles.
  - REPORT follows. With defaults it is cycle 21; lane_detect_o and the new lanes_present_o are visible in cycle 21.
- Latency from detect_active_i to lane_detect_o: SETTLE_CYCLES+SAMPLE_CYCLES+1 cycles.
- rxdet_en_o, tx_elec_idle_o, busy_o and lane_detect_o are decoded from the registered state only (no input-to-output combinational path).
- Reset mid-operation: asynchronous return to reset values; any pulse in flight is lost.

## Structure
- ltssm_pkg gains rxdet_sm_e (the six states).
- The per-lane AND accumulator is a sub-module, rxdet_lane_filter: clk_i, rst_ni, clr_i, en_i, cmp_i[NUM_LANES], acc_o[NUM_LANES].
- FSM and counter live in the top module.

## Test plan
Defaults for all scenarios: NUM_LANES=4, SETTLE_CYCLES=16, SAMPLE_CYCLES=4, RETRY_GAP=8.
- Lanes 0 and 2 present: rxdet_cmp_i=4'b0101 steady, detect_active_i rises → rxdet_en_o=4'hF cycles 1–20, lane_detect_o high cycle 21 only, lanes_present_o=4'b0101, then HOLDOFF until detect_active_i drops.
- Glitchy lane: lane 1 comparator high except the 3rd SAMPLE cycle, others 0 → no pulse, lanes_present_o=0, RETRY 8 cycles, CHARGE restarts at cycle 30.
- Abort: detect_active_i falls in CHARGE cycle 10 → rxdet_en_o=0 cycle 11, state IDLE, lanes_present_o unchanged, lane_detect_o never asserts.
- Abort priority: detect_active_i falls in the last SAMPLE cycle with cmp=4'hF → IDLE, no pulse, lanes_present_o unchanged.
- Async reset asserted during SAMPLE → all outputs at reset values immediately; after release with detect_active_i high, the full sequence restarts and pulses at cycle 21.
- Loop with a Detect controller model: the controller leaves Detect.Active on lane_detect_o, and the sequencer returns to IDLE exactly one cycle after detect_active_i falls.
